prbs_checker: RTL and testbench

Serial receiver-side checker for the 5-bit PRBS stream produced by the team's LFSR generator (recurrence s[n] = s[n-2] ^ s[n-5], period 31). It self-synchronises to the incoming bit stream and then runs a local free-running copy of the sequence. It flags every mismatched bit and accumulates bit and error counts for link/power-state verification. It sits at the far end of any link the generator drives, one bit per qualified cycle.

---
 rtl/prbs_pkg.sv | 7 +
 rtl/prbs_sat_cnt.sv | 15 +
 rtl/prbs_checker.sv | 83 ++++++++
 tb/tb_prbs_checker.sv | 95 +++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS constants and checker state type
package prbs_pkg;
  localparam int PRBS_LEN = 5;
  localparam int TAP_A = 1;
  localparam int TAP_B = 4;
  typedef enum logic {HUNT, LOCKED} state_e;
endpackage

// File: rtl/prbs_sat_cnt.sv
// prbs_sat_cnt: saturating counter with increment and synchronous clear
module prbs_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign count = cnt_q;
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS5 checker with error and bit counters
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_bit,
  input  logic                clear,
  output logic                locked,
  output logic                err,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    bit_count,
  output logic [PRBS_LEN-1:0] reg_out
);
  state_e              state_d, state_q;
  logic [PRBS_LEN-1:0] h_d, h_q;
  logic [2:0]          fill_d, fill_q;
  logic [7:0]          good_d, good_q;
  logic [3:0]          miss_d, miss_q;
  logic                err_d, err_q;
  logic                p, mis, lk, hunt_cmp;
  always_comb begin
    p        = h_q[TAP_A] ^ h_q[TAP_B];
    mis      = in_bit != p;
    lk       = state_q == LOCKED;
    hunt_cmp = in_valid && !lk && fill_q == 3'(PRBS_LEN);
    state_d  = state_q;
    h_d      = h_q;
    fill_d   = fill_q;
    good_d   = good_q;
    miss_d   = miss_q;
    err_d    = in_valid && lk && mis;
    if (in_valid) begin
      h_d = {h_q[PRBS_LEN-2:0], lk ? p : in_bit};
      if (!lk) begin
        fill_d = hunt_cmp ? fill_q : fill_q + 3'd1;
        good_d = !hunt_cmp ? good_q : (h_q != '0 && !mis) ? good_q + 8'd1 : 8'd0;
        if (good_d == 8'(LOCK_CNT)) begin
          state_d = LOCKED;
          miss_d  = '0;
        end
      end else begin
        miss_d = mis ? miss_q + 4'd1 : 4'd0;
        if (miss_d == 4'(UNLOCK_ERRS)) begin
          state_d = HUNT;
          fill_d  = '0;
          good_d  = '0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      h_q     <= '0;
      fill_q  <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end
  prbs_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(err_d), .count(err_count)
  );
  prbs_sat_cnt #(.W(CNT_W)) u_bit_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(in_valid && lk), .count(bit_count)
  );
  assign locked  = lk;
  assign err     = err_q;
  assign reg_out = h_q;
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: scoreboard bench for prbs_checker with directed vectors
module tb_prbs_checker;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_bit = 1'b0, clear = 1'b0;
  logic        locked, err;
  logic [15:0] err_count, bit_count;
  logic [4:0]  reg_out;
  typedef struct {
    logic        lk;
    logic        e;
    logic [15:0] ec;
    logic [15:0] bc;
    logic        chk_h;
    logic [4:0]  h;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t x;
  int   compared = 0, mismatched = 0;
  logic seq [31];
  int   idx = 0;
  logic b;
  prbs_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .locked(locked), .err(err), .err_count(err_count), .bit_count(bit_count), .reg_out(reg_out)
  );
  always #5 clk = ~clk;
  task automatic step(input logic v, input logic bi, input logic c, input logic r,
                      input logic elk, input logic ee, input int eec, input int ebc,
                      input logic ch, input logic [4:0] eh, input string nm);
    exp_t t;
    @(negedge clk);
    in_valid = v;
    in_bit   = bi;
    clear    = c;
    rst      = r;
    t.lk = elk; t.e = ee; t.ec = 16'(eec); t.bc = 16'(ebc); t.chk_h = ch; t.h = eh; t.name = nm;
    sb.push_back(t);
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      compared++;
      if ({locked, err, err_count, bit_count} !== {x.lk, x.e, x.ec, x.bc} || (x.chk_h && reg_out !== x.h)) begin
        mismatched++;
        $display("FAIL %s: got locked=%0b err=%0b ec=%0d bc=%0d h=%b, want locked=%0b err=%0b ec=%0d bc=%0d h=%b",
                 x.name, locked, err, err_count, bit_count, reg_out, x.lk, x.e, x.ec, x.bc, x.h);
      end
    end
  end
  initial begin
    seq[0] = 1; seq[1] = 0; seq[2] = 0; seq[3] = 0; seq[4] = 0;
    for (int i = 5; i < 31; i++) seq[i] = seq[i-2] ^ seq[i-5];
    step(0, 0, 0, 1, 0, 0, 0, 0, 1, 5'd0, "reset");
    for (int i = 1; i <= 13; i++) begin
      b = seq[idx % 31]; idx++;
      step(1, b, 0, 0, i == 13, 0, 0, 0, i == 13, 5'b01110, "lock");
    end
    for (int i = 1; i <= 100; i++) begin
      b = seq[idx % 31]; idx++;
      step(1, b, 0, 0, 1, 0, 0, i, 0, 5'd0, "clean100");
    end
    b = !seq[idx % 31]; idx++;
    step(1, b, 0, 0, 1, 1, 1, 101, 0, 5'd0, "flip1");
    step(0, 0, 0, 0, 1, 0, 1, 101, 0, 5'd0, "idle");
    for (int i = 1; i <= 31; i++) begin
      b = seq[idx % 31]; idx++;
      step(1, b, 0, 0, 1, 0, 1, 101 + i, 0, 5'd0, "clean31");
    end
    step(0, 0, 1, 0, 1, 0, 0, 0, 0, 5'd0, "clear_idle");
    for (int i = 1; i <= 4; i++) begin
      b = !seq[idx % 31]; idx++;
      step(1, b, 0, 0, i < 4, 1, i, i, 0, 5'd0, "burst");
    end
    for (int i = 1; i <= 13; i++) begin
      b = seq[idx % 31]; idx++;
      step(1, b, 0, 0, i == 13, 0, 4, 4, 0, 5'd0, "relock");
    end
    b = !seq[idx % 31]; idx++;
    step(1, b, 1, 0, 1, 1, 0, 0, 0, 5'd0, "clear_err");
    b = !seq[idx % 31]; idx++;
    step(1, b, 0, 1, 0, 0, 0, 0, 1, 5'd0, "rst_mid");
    for (int i = 1; i <= 50; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0, "zeros");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0, "final_idle");
    @(posedge clk);
    #2;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
